// File: rtl/ex_mem_stage_if.sv
// ID/EX -> EX/MEM stage bundle: decoded operands, MEM/WB forwarding path, registered EX/MEM outputs.
// Latency: n/a (wiring only).
// Backpressure: stall is driven by the stage and holds the upstream pipeline registers.
interface ex_mem_stage_if;
  logic [1:0]  id_wb;        // {RegWrite, MemtoReg}
  logic [1:0]  id_m;         // {MemRead, MemWrite}
  logic [3:0]  id_ex;        // {RegDst, ALUOp[1:0], ALUSrc}
  logic [31:0] id_r1;
  logic [31:0] id_r2;
  logic [31:0] id_imm;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [1:0]  ex_wb;
  logic [1:0]  ex_m;
  logic [31:0] ex_alu;
  logic [31:0] ex_sdata;
  logic [4:0]  ex_dst;
  logic        stall;

  modport master (
    output id_wb, id_m, id_ex, id_r1, id_r2, id_imm, id_rs, id_rt, id_rd,
    output wb_regwrite, wb_rd, wb_data,
    input  ex_wb, ex_m, ex_alu, ex_sdata, ex_dst, stall
  );

  modport slave (
    input  id_wb, id_m, id_ex, id_r1, id_r2, id_imm, id_rs, id_rt, id_rd,
    input  wb_regwrite, wb_rd, wb_data,
    output ex_wb, ex_m, ex_alu, ex_sdata, ex_dst, stall
  );
endinterface

// File: rtl/ex_mem_stage.sv
// Execute stage with operand forwarding, ALU and a 32-cycle shift-add multiplier feeding the EX/MEM register.
// Latency: 1 edge for single-cycle ops; mul result lands 34 edges after first presentation.
// Backpressure: stall (combinational) is high for 33 cycles per mul; EX/MEM takes bubbles meanwhile.
module ex_mem_stage (
  input  logic            clk,
  input  logic            rst,
  ex_mem_stage_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_MUL = 6'h18;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] acc_q, acc_d;
  logic [1:0]  mwb_q, mwb_d;
  logic [1:0]  mm_q, mm_d;
  logic [4:0]  mdst_q, mdst_d;

  logic [1:0]  ex_wb_q, ex_wb_d;
  logic [1:0]  ex_m_q, ex_m_d;
  logic [31:0] ex_alu_q, ex_alu_d;
  logic [31:0] ex_sdata_q, ex_sdata_d;
  logic [4:0]  ex_dst_q, ex_dst_d;

  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic [31:0] alu_b;
  logic [31:0] alu_res;
  logic [4:0]  dst;
  logic        is_mul;
  logic        stall;

  // Forwarding muxes (EX/MEM beats MEM/WB, r0 never forwarded), operand select and ALU.
  always_comb begin
    alu_op = bus.id_ex[2:1];
    funct  = bus.id_imm[5:0];

    fwd_a = bus.id_r1;
    if (ex_wb_q[1] && (ex_dst_q != 5'd0) && (ex_dst_q == bus.id_rs)) begin
      fwd_a = ex_alu_q;
    end else if (bus.wb_regwrite && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.id_rs)) begin
      fwd_a = bus.wb_data;
    end

    fwd_b = bus.id_r2;
    if (ex_wb_q[1] && (ex_dst_q != 5'd0) && (ex_dst_q == bus.id_rt)) begin
      fwd_b = ex_alu_q;
    end else if (bus.wb_regwrite && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.id_rt)) begin
      fwd_b = bus.wb_data;
    end

    alu_b = bus.id_ex[0] ? bus.id_imm : fwd_b;
    dst   = bus.id_ex[3] ? bus.id_rd : bus.id_rt;

    alu_res = 32'd0;
    case (alu_op)
      2'b00: alu_res = fwd_a + alu_b;
      2'b01: alu_res = fwd_a - alu_b;
      2'b11: alu_res = fwd_a | alu_b;
      default: begin
        case (funct)
          FN_ADD:  alu_res = fwd_a + alu_b;
          FN_SUB:  alu_res = fwd_a - alu_b;
          FN_AND:  alu_res = fwd_a & alu_b;
          FN_OR:   alu_res = fwd_a | alu_b;
          FN_SLT:  alu_res = {31'd0, ($signed(fwd_a) < $signed(alu_b))};
          default: alu_res = 32'd0;  // mul is produced by the FSM, not here
        endcase
      end
    endcase

    is_mul = (alu_op == 2'b10) && (funct == FN_MUL);
  end

  // Multiplier FSM and next EX/MEM contents; bubbles while the multiplier owns the stage.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    mwb_d      = mwb_q;
    mm_d       = mm_q;
    mdst_d     = mdst_q;
    stall      = 1'b0;
    ex_wb_d    = bus.id_wb;
    ex_m_d     = bus.id_m;
    ex_alu_d   = alu_res;
    ex_sdata_d = fwd_b;
    ex_dst_d   = dst;

    case (state_q)
      S_IDLE: begin
        if (is_mul) begin
          stall      = 1'b1;
          mcand_d    = fwd_a;
          mplier_d   = alu_b;
          acc_d      = 32'd0;
          cnt_d      = 5'd0;
          mwb_d      = bus.id_wb;
          mm_d       = bus.id_m;
          mdst_d     = dst;
          ex_wb_d    = 2'd0;
          ex_m_d     = 2'd0;
          ex_alu_d   = 32'd0;
          ex_sdata_d = 32'd0;
          ex_dst_d   = 5'd0;
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        stall      = 1'b1;
        ex_wb_d    = 2'd0;
        ex_m_d     = 2'd0;
        ex_alu_d   = 32'd0;
        ex_sdata_d = 32'd0;
        ex_dst_d   = 5'd0;
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = {mcand_q[30:0], 1'b0};
        mplier_d = {1'b0, mplier_q[31:1]};
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Input is ignored here: the mul still sitting on the bus is the one being retired.
        ex_wb_d    = mwb_q;
        ex_m_d     = mm_q;
        ex_alu_d   = acc_q;
        ex_sdata_d = 32'd0;
        ex_dst_d   = mdst_q;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and EX/MEM registers; reset wins over everything, aborting any mul in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 5'd0;
      mcand_q    <= 32'd0;
      mplier_q   <= 32'd0;
      acc_q      <= 32'd0;
      mwb_q      <= 2'd0;
      mm_q       <= 2'd0;
      mdst_q     <= 5'd0;
      ex_wb_q    <= 2'd0;
      ex_m_q     <= 2'd0;
      ex_alu_q   <= 32'd0;
      ex_sdata_q <= 32'd0;
      ex_dst_q   <= 5'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      mwb_q      <= mwb_d;
      mm_q       <= mm_d;
      mdst_q     <= mdst_d;
      ex_wb_q    <= ex_wb_d;
      ex_m_q     <= ex_m_d;
      ex_alu_q   <= ex_alu_d;
      ex_sdata_q <= ex_sdata_d;
      ex_dst_q   <= ex_dst_d;
    end
  end

  assign bus.ex_wb    = ex_wb_q;
  assign bus.ex_m     = ex_m_q;
  assign bus.ex_alu   = ex_alu_q;
  assign bus.ex_sdata = ex_sdata_q;
  assign bus.ex_dst   = ex_dst_q;
  assign bus.stall    = stall;

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have clk  input  1  rising-edge clock.
REQ-002 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have id_wb/id_m  input  2/2  {RegWrite,MemtoReg} / {MemRead,MemWrite} from ID/EX.
REQ-004 SHALL have id_ex  input  4  {RegDst, ALUOp[1:0], ALUSrc} from ID/EX.
REQ-005 SHALL have id_r1, id_r2, id_imm  input  32 each  rs data, rt data, sign-extended immediate (funct = id_imm[5:0]).
REQ-006 SHALL have id_rs, id_rt, id_rd  input  5 each  register specifiers.
REQ-007 SHALL have wb_regwrite 1, wb_rd 5, wb_data 32  inputs  MEM/WB writeback for forwarding.
REQ-008 SHALL have ex_wb 2, ex_m 2, ex_alu 32, ex_sdata 32, ex_dst 5  outputs  registered EX/MEM contents.
REQ-009 SHALL have stall  output  1  combinational; upstream holds PC, IF/ID and ID/EX while high.

Function
REQ-010 Forward A SHALL select ex_alu if ex_wb[1] && ex_dst!=0 && ex_dst==id_rs, else wb_data if wb_regwrite && wb_rd!=0 && wb_rd==id_rs, else id_r1; EX/MEM priority over MEM/WB.
REQ-011 Forward B SHALL apply REQ-010 rules to id_rt/id_r2; result is fwdB.
REQ-012 ALU operand B SHALL be id_imm when ALUSrc=1, else fwdB; ex_sdata SHALL capture fwdB.
REQ-013 ALU op SHALL be: ALUOp 00 add; 01 sub; 11 or; 10 by funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed, result 0/1), 0x18 mul; other funct yields 0.
REQ-014 add/sub SHALL wrap modulo 2^32; no overflow detection.
REQ-015 ex_dst SHALL be id_rd when RegDst=1, else id_rt.
REQ-016 Single-cycle ops SHALL load EX/MEM on the edge ending the cycle they are presented; latency 1.
REQ-017 mul SHALL use FSM IDLE->BUSY->DONE->IDLE, shift-add one multiplier bit per cycle, result = low 32 bits of signed-agnostic product.
REQ-018 IDLE with mul presented: stall=1, forwarded operands latched into multiplicand/multiplier, counter=0, EX/MEM loads bubble (all fields 0), next state BUSY.
REQ-019 BUSY: stall=1, one iteration per cycle, EX/MEM loads bubble; after 32 BUSY cycles (counter 31) next state DONE.
REQ-020 DONE: stall=0, EX/MEM loads product with the held mul's id_wb/id_m/dst, next state IDLE; mul on input in DONE SHALL NOT retrigger.
REQ-021 mul total: 33 stall cycles; product visible on ex_alu 34 edges after first presentation.
REQ-022 Operand values SHALL be those forwarded in the IDLE detection cycle; later input changes ignored.
REQ-023 Bubble SHALL zero ex_wb and ex_m so no write or memory access occurs.
REQ-024 stall SHALL be 0 in IDLE whenever no mul is presented.

Reset
REQ-025 rst SHALL clear ex_wb, ex_m, ex_alu, ex_sdata, ex_dst to 0, FSM to IDLE, counter and mul registers to 0.
REQ-026 rst during BUSY/DONE SHALL abort the mul; no product written; stall=0 the cycle after rst unless a mul is presented.
REQ-027 rst SHALL take priority over every other update in the same cycle.

Verification
REQ-028 add: r1=5, r2=7, ALUOp=10, funct 0x20, RegDst=1, rd=3 -> next edge ex_alu=12, ex_dst=3, stall=0 throughout.
REQ-029 Double hazard: EX/MEM holds dst=4 result 0x10; wb_rd=4, wb_data=0x20; next instr rs=4, r1=0, add imm 1 -> ex_alu=0x11 (EX/MEM wins); rs=0 case -> no forward.
REQ-030 lw-style: ALUOp=00, ALUSrc=1, r1=0x100, imm=0xFFFFFFFC, r2=9 -> ex_alu=0xFC, ex_sdata=9, ex_dst=rt.
REQ-031 mul 6 x 0xFFFFFFFD held 34 cycles -> stall high 33 cycles, 33 bubbles, then ex_alu=0xFFFFFFEE, stall low; following add completes normally.
REQ-032 rst asserted at BUSY counter=10 -> all outputs 0, state IDLE next cycle; re-presented mul 3x4 -> ex_alu=12 after 34 edges.
REQ-033 slt r1=0xFFFFFFFF, r2=1 -> ex_alu=1; swapped -> 0.
